// File: rtl/alu_ctrl_md.sv
// ALU control decoder for the unpipelined MIPS core, with a registered valid/ready
// issue port and an iterative unsigned MULTU/DIVU engine driving HI/LO.
module alu_ctrl_md #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_aluop,
    input  logic [5:0]      i_funct,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    output logic            o_out_valid,
    output logic [3:0]      o_control,
    output logic            o_illegal,
    output logic            o_busy,
    output logic            o_md_done,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    localparam logic [3:0] CODE_AND = 4'b0000;
    localparam logic [3:0] CODE_OR  = 4'b0001;
    localparam logic [3:0] CODE_ADD = 4'b0010;
    localparam logic [3:0] CODE_SUB = 4'b0110;
    localparam logic [3:0] CODE_SLT = 4'b0111;
    localparam logic [3:0] CODE_NOR = 4'b1100;
    localparam logic [3:0] CODE_ILL = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      control_q, control_d;
    logic            out_valid_q, out_valid_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mq_q, mq_d;
    logic [XLEN-1:0] opb_q, opb_d;

    logic [3:0]      dec_code;
    logic            dec_illegal;
    logic            dec_mul;
    logic            dec_div;

    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_acc;
    logic [XLEN-1:0] mul_mq;
    logic [XLEN:0]   div_sh;
    logic            div_ok;
    logic [XLEN-1:0] div_diff;
    logic [XLEN-1:0] div_acc;
    logic [XLEN-1:0] div_mq;
    logic            last_iter;

    always_comb begin
        dec_code    = CODE_ILL;
        dec_illegal = 1'b0;
        dec_mul     = 1'b0;
        dec_div     = 1'b0;
        unique case (i_aluop)
            2'b00: dec_code = CODE_ADD;
            2'b01: dec_code = CODE_SUB;
            2'b10: begin
                unique case (i_funct)
                    6'b100000: dec_code = CODE_ADD;
                    6'b100010: dec_code = CODE_SUB;
                    6'b100100: dec_code = CODE_AND;
                    6'b100101: dec_code = CODE_OR;
                    6'b100111: dec_code = CODE_NOR;
                    6'b101010: dec_code = CODE_SLT;
                    6'b011001: dec_mul  = 1'b1;
                    6'b011011: dec_div  = 1'b1;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Multiply: {acc, mq} is the product register, mq starts as the multiplier.
    always_comb begin
        mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
        mul_acc = mul_sum[XLEN:1];
        mul_mq  = {mul_sum[0], mq_q[XLEN-1:1]};
    end

    // Restoring divide: acc is the partial remainder, mq shifts dividend out and
    // quotient in. A zero divisor always "fits", giving all-ones / dividend.
    always_comb begin
        div_sh   = {acc_q, mq_q[XLEN-1]};
        div_ok   = (div_sh >= {1'b0, opb_q});
        div_diff = div_sh[XLEN-1:0] - opb_q;
        div_acc  = div_ok ? div_diff : div_sh[XLEN-1:0];
        div_mq   = {mq_q[XLEN-2:0], div_ok};
    end

    assign last_iter = (cnt_q == CW'(XLEN - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        control_d   = control_q;
        out_valid_d = 1'b0;
        illegal_d   = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        acc_d       = acc_q;
        mq_d        = mq_q;
        opb_d       = opb_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    if (dec_mul) begin
                        state_d = S_MUL;
                        cnt_d   = '0;
                        acc_d   = '0;
                        mq_d    = i_op2;
                        opb_d   = i_op1;
                    end else if (dec_div) begin
                        state_d = S_DIV;
                        cnt_d   = '0;
                        acc_d   = '0;
                        mq_d    = i_op1;
                        opb_d   = i_op2;
                    end else begin
                        out_valid_d = 1'b1;
                        control_d   = dec_code;
                        illegal_d   = dec_illegal;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (state_q == S_MUL) begin
                    acc_d = mul_acc;
                    mq_d  = mul_mq;
                end else begin
                    acc_d = div_acc;
                    mq_d  = div_mq;
                end
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    hi_d    = acc_d;
                    lo_d    = mq_d;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            control_q   <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            acc_q       <= '0;
            mq_q        <= '0;
            opb_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            control_q   <= control_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            acc_q       <= acc_d;
            mq_q        <= mq_d;
            opb_q       <= opb_d;
        end
    end

    assign o_ready     = (state_q == S_IDLE);
    assign o_busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign o_md_done   = (state_q == S_DONE);
    assign o_out_valid = out_valid_q;
    assign o_control   = control_q;
    assign o_illegal   = illegal_q;
    assign o_hi        = hi_q;
    assign o_lo        = lo_q;

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed bench for alu_ctrl_md: decode sweep, illegal codes, MULTU/DIVU timing and
// results, divide by zero, mid-operation reset and operand latching.
module tb_alu_ctrl_md;

    localparam int unsigned XLEN = 32;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_valid;
    logic            o_ready;
    logic [1:0]      i_aluop;
    logic [5:0]      i_funct;
    logic [XLEN-1:0] i_op1;
    logic [XLEN-1:0] i_op2;
    logic            o_out_valid;
    logic [3:0]      o_control;
    logic            o_illegal;
    logic            o_busy;
    logic            o_md_done;
    logic [XLEN-1:0] o_hi;
    logic [XLEN-1:0] o_lo;

    int unsigned checks;
    int unsigned failures;

    alu_ctrl_md #(.XLEN(XLEN)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_aluop     (i_aluop),
        .i_funct     (i_funct),
        .i_op1       (i_op1),
        .i_op2       (i_op2),
        .o_out_valid (o_out_valid),
        .o_control   (o_control),
        .o_illegal   (o_illegal),
        .o_busy      (o_busy),
        .o_md_done   (o_md_done),
        .o_hi        (o_hi),
        .o_lo        (o_lo)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Issue MULTU/DIVU and follow it cycle by cycle; cycle n is the interval after
    // the n-th rising edge counted from the accept edge.
    task automatic md_op(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic hold_add, input logic toggle);
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        prev_hi = o_hi;
        prev_lo = o_lo;
        i_valid = 1'b1;
        i_aluop = 2'b10;
        i_funct = funct;
        i_op1   = a;
        i_op2   = b;
        tick();
        if (hold_add) i_aluop = 2'b00;
        else i_valid = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            if (toggle && c >= 2 && c <= 9) begin
                i_op1 = $urandom;
                i_op2 = $urandom;
            end
            chk("md_busy", o_busy, 1);
            chk("md_ready_low", o_ready, 0);
            chk("md_no_outvalid", o_out_valid, 0);
            chk("md_hi_stable", o_hi, prev_hi);
            chk("md_lo_stable", o_lo, prev_lo);
            tick();
        end
        chk("md_done", o_md_done, 1);
        chk("md_done_busy", o_busy, 0);
        chk("md_done_ready", o_ready, 0);
        chk("md_hi", o_hi, exp_hi);
        chk("md_lo", o_lo, exp_lo);
        tick();
        chk("md_ready_back", o_ready, 1);
        chk("md_done_clear", o_md_done, 0);
        if (hold_add) begin
            tick();
            chk("held_add_valid", o_out_valid, 1);
            chk("held_add_code", o_control, 4'b0010);
            chk("held_add_illegal", o_illegal, 0);
            i_valid = 1'b0;
            tick();
            chk("held_add_pulse", o_out_valid, 0);
        end
    endtask

    logic [1:0] sw_aluop [8];
    logic [5:0] sw_funct [8];
    logic [3:0] sw_code  [8];

    initial begin
        checks   = 0;
        failures = 0;
        sw_aluop = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        sw_funct = '{6'b000000, 6'b000000, 6'b100000, 6'b100010,
                     6'b100100, 6'b100101, 6'b100111, 6'b101010};
        sw_code  = '{4'b0010, 4'b0110, 4'b0010, 4'b0110,
                     4'b0000, 4'b0001, 4'b1100, 4'b0111};

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_aluop = 2'b00;
        i_funct = 6'b0;
        i_op1   = '0;
        i_op2   = '0;
        repeat (3) tick();
        chk("rst_control", o_control, 0);
        chk("rst_outvalid", o_out_valid, 0);
        chk("rst_illegal", o_illegal, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_md_done, 0);
        chk("rst_hi", o_hi, 0);
        chk("rst_lo", o_lo, 0);
        chk("rst_ready", o_ready, 1);
        i_rst_n = 1'b1;
        tick();
        chk("post_rst_ready", o_ready, 1);
        chk("post_rst_outvalid", o_out_valid, 0);

        // Back-to-back decode sweep
        for (int k = 0; k < 8; k++) begin
            i_valid = 1'b1;
            i_aluop = sw_aluop[k];
            i_funct = sw_funct[k];
            tick();
            chk("sweep_valid", o_out_valid, 1);
            chk("sweep_code", o_control, sw_code[k]);
            chk("sweep_illegal", o_illegal, 0);
            chk("sweep_ready", o_ready, 1);
        end
        i_valid = 1'b0;
        tick();
        chk("sweep_pulse_end", o_out_valid, 0);
        chk("sweep_code_hold", o_control, 4'b0111);

        i_valid = 1'b1;
        i_aluop = 2'b10;
        i_funct = 6'b000000;
        tick();
        i_valid = 1'b0;
        chk("ill_funct_valid", o_out_valid, 1);
        chk("ill_funct_code", o_control, 4'b1111);
        chk("ill_funct_flag", o_illegal, 1);
        tick();
        chk("ill_funct_pulse", o_illegal, 0);
        chk("ill_funct_hold", o_control, 4'b1111);

        i_valid = 1'b1;
        i_aluop = 2'b11;
        i_funct = 6'b100000;
        tick();
        i_valid = 1'b0;
        chk("ill_aluop_valid", o_out_valid, 1);
        chk("ill_aluop_code", o_control, 4'b1111);
        chk("ill_aluop_flag", o_illegal, 1);
        chk("ill_hi_untouched", o_hi, 0);
        tick();
        chk("ill_aluop_pulse", o_illegal, 0);

        md_op(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0);
        md_op(6'b011011, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 1'b0);
        md_op(6'b011011, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Mid-operation reset
        i_valid = 1'b1;
        i_aluop = 2'b10;
        i_funct = 6'b011001;
        i_op1   = 32'd3;
        i_op2   = 32'd5;
        tick();
        i_valid = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (c >= 2) begin
                i_op1 = $urandom;
                i_op2 = $urandom;
            end
            tick();
        end
        chk("midrst_busy_before", o_busy, 1);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_ready", o_ready, 1);
        chk("midrst_done", o_md_done, 0);
        chk("midrst_hi", o_hi, 0);
        chk("midrst_lo", o_lo, 0);
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("midrst_idle", o_ready, 1);

        md_op(6'b011001, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
